// File: rtl/booth_multiplier_seq_if.sv
// ---------------------------------------------------------------------------
// booth_multiplier_seq_if
// Operand/result bundle between an operand source (master) and the
// sequential Booth multiplier (slave).
//
// Handshake: the master raises start with operands and signed_mode valid in
// the same cycle. The request is accepted on the first rising edge where
// busy is low. busy then stays high until the result cycle has passed. Any
// start seen while busy is high is dropped, not queued. done is a single-cycle
// pulse marking the cycle in which product first holds the new result.
// product keeps that value until the next done.
//
// Signals
//   start         master->slave  request
//   signed_mode   master->slave  1: two's complement operands, 0: unsigned
//   multiplicand  master->slave  operand A (WIDTH bits)
//   multiplier    master->slave  operand B (WIDTH bits)
//   busy          slave->master  operation in flight
//   done          slave->master  one-cycle result pulse
//   product       slave->master  2*WIDTH-bit result register
// ---------------------------------------------------------------------------
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// ---------------------------------------------------------------------------
// booth_multiplier_seq
// Sequential radix-2 Booth multiplier. It performs one add/sub-and-shift step
// per clock and carries out WIDTH+1 steps per operation. Both signed and
// unsigned operands are supported, because each operand is extended by one
// bit before the steps begin.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   bus          slave modport of booth_multiplier_seq_if (start/operands in,
//                busy/done/product out)
//   dbg_state_o  out  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Timing: a start accepted at edge t is followed by steps at edges
// t+1 .. t+WIDTH+1. The last step also loads product and enters DONE.
// Edge t+WIDTH+2 returns the FSM to IDLE.
// ---------------------------------------------------------------------------
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  booth_multiplier_seq_if.slave        bus,
  output logic [1:0]                   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH so that the final (WIDTH+1)th step
  // is recognised before any wrap.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;      // accumulator (extended width)
  logic [WIDTH:0]     q_q, q_d;      // multiplier / low product bits
  logic               qm1_q, qm1_d;  // Q_-1
  logic [WIDTH:0]     m_q, m_d;      // extended multiplicand
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Booth step datapath
  logic [WIDTH:0] a_sum;
  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] q_sh;
  logic           qm1_sh;

  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    // Arithmetic right shift of {A,Q,Q_-1}. The MSB of A is replicated.
    {a_sh, q_sh, qm1_sh} = {a_sum[WIDTH], a_sum, q_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Extend each operand by one bit. In signed mode the sign bit is
          // copied; in unsigned mode a zero is added, so the operand stays
          // positive.
          m_d     = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
          q_d     = {bus.signed_mode & bus.multiplier[WIDTH-1], bus.multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = qm1_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          // The full {A,Q} result is 2*WIDTH+2 bits. Only the low 2*WIDTH bits
          // are kept; they are exact for both signed and unsigned operands.
          product_d = {a_sh[WIDTH-2:0], q_sh};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.product  = product_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

  logic clock;
  logic reset;
  logic [1:0] dbg8;
  logic [1:0] dbg4;

  int n_cmp;
  int n_bad;

  booth_multiplier_seq_if #(.WIDTH(8)) bus8 ();
  booth_multiplier_seq_if #(.WIDTH(4)) bus4 ();

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus8),
    .dbg_state_o (dbg8)
  );

  booth_multiplier_seq #(.WIDTH(4)) dut4 (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus4),
    .dbg_state_o (dbg4)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  // Caller is at a negedge. Drives start now. Returns at the negedge after the
  // edge that leaves DONE. lat is the count of edges from accept to done
  // (-1 on timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output logic [15:0] p, output int lat,
                        output logic busy_mid, output logic busy_after);
    p = 16'h0;
    lat = -1;
    bus8.start = 1'b1;
    bus8.multiplicand = a;
    bus8.multiplier = b;
    bus8.signed_mode = sm;
    @(posedge clock);
    @(negedge clock);
    bus8.start = 1'b0;
    busy_mid = bus8.busy;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (bus8.done === 1'b1) begin
        lat = k;
        p = bus8.product;
        break;
      end
    end
    @(negedge clock);
    busy_after = bus8.busy;
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                         output logic [7:0] p, output int lat);
    p = 8'h0;
    lat = -1;
    bus4.start = 1'b1;
    bus4.multiplicand = a;
    bus4.multiplier = b;
    bus4.signed_mode = sm;
    @(posedge clock);
    @(negedge clock);
    bus4.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (bus4.done === 1'b1) begin
        lat = k;
        p = bus4.product;
        break;
      end
    end
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0;
    bus8.multiplicand = 8'h0; bus8.multiplier = 8'h0;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0;
    bus4.multiplicand = 4'h0; bus4.multiplier = 4'h0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.product} !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b product=%h, want 0/0/0000",
               bus8.busy, bus8.done, bus8.product);
    end
    n_cmp++;
    if (dbg8 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d, want 0", dbg8);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus8.busy !== 1'b0 || bus4.busy !== 1'b0 || bus4.product !== 8'h0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy8=%b busy4=%b product4=%h, want 0/0/00",
               bus8.busy, bus4.busy, bus4.product);
    end
  endtask

  task automatic test_signed_basic();
    logic [15:0] p; int lat; logic bm, ba;
    run_op(8'hFD, 8'h05, 1'b1, p, lat, bm, ba);
    n_cmp++;
    if (p !== 16'hFFF1) begin
      n_bad++; $display("FAIL signed_m3x5: got %h, want fff1", p);
    end
    n_cmp++;
    if (lat !== 9) begin
      n_bad++; $display("FAIL latency: got %0d edges, want 9", lat);
    end
    n_cmp++;
    if (bm !== 1'b1 || ba !== 1'b0) begin
      n_bad++; $display("FAIL busy_window: got mid=%b after=%b, want 1/0", bm, ba);
    end
  endtask

  task automatic test_vectors();
    logic [7:0]  va [8] = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'h7F, 8'h80, 8'h80};
    logic [7:0]  vb [8] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'hA5, 8'h7F, 8'h80, 8'h01};
    logic        vs [8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [15:0] ve [8] = '{16'hFE01, 16'h0001, 16'h4000, 16'hC080,
                            16'h0000, 16'h3F01, 16'h4000, 16'hFF80};
    logic [15:0] p; int lat; logic bm, ba;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vs[i], p, lat, bm, ba);
      n_cmp++;
      if (p !== ve[i] || lat !== 9) begin
        n_bad++;
        $display("FAIL vector%0d (%h*%h s=%b): got %h lat %0d, want %h lat 9",
                 i, va[i], vb[i], vs[i], p, lat, ve[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones; logic [15:0] first_p; int first_k;
    dones = 0; first_p = 16'h0; first_k = -1;
    bus8.start = 1'b1; bus8.multiplicand = 8'hFD; bus8.multiplier = 8'h05;
    bus8.signed_mode = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus8.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (k == 3) begin
        bus8.start = 1'b1; bus8.multiplicand = 8'h7F; bus8.multiplier = 8'h7F;
        bus8.signed_mode = 1'b0;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.done === 1'b1) begin
        dones++;
        if (first_k < 0) begin first_k = k; first_p = bus8.product; end
      end
    end
    n_cmp++;
    if (dones !== 1 || first_p !== 16'hFFF1 || first_k !== 9) begin
      n_bad++;
      $display("FAIL ignore_start: got dones=%0d product=%h at %0d, want 1 fff1 at 9",
               dones, first_p, first_k);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p1, p2; int l1, l2; logic bm, ba;
    run_op(8'h80, 8'h80, 1'b1, p1, l1, bm, ba);
    run_op(8'h7F, 8'h80, 1'b1, p2, l2, bm, ba);
    n_cmp++;
    if (p1 !== 16'h4000 || p2 !== 16'hC080 || l2 !== 9) begin
      n_bad++;
      $display("FAIL back_to_back: got %h,%h lat2=%0d, want 4000,c080 lat2=9", p1, p2, l2);
    end
  endtask

  task automatic test_hold();
    logic [15:0] p; int lat; logic bm, ba; int changes; logic [15:0] fin;
    changes = 0; fin = 16'h0;
    run_op(8'h02, 8'h03, 1'b0, p, lat, bm, ba);
    bus8.start = 1'b1; bus8.multiplicand = 8'hFF; bus8.multiplier = 8'hFF;
    bus8.signed_mode = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus8.start = 1'b0;
    bus8.multiplicand = 8'h11; bus8.multiplier = 8'h22; bus8.signed_mode = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k < 9 && bus8.product !== 16'h0006) changes++;
      if (k == 9) fin = bus8.product;
    end
    @(negedge clock);
    n_cmp++;
    if (changes !== 0 || fin !== 16'hFE01) begin
      n_bad++;
      $display("FAIL product_hold: got %0d early changes final=%h, want 0 and fe01",
               changes, fin);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    dones = 0;
    bus8.start = 1'b1; bus8.multiplicand = 8'h7F; bus8.multiplier = 8'h7F;
    bus8.signed_mode = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus8.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0 || dbg8 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_abort: got busy=%b done=%b product=%h state=%0d, want 0/0/0000/0",
               bus8.busy, bus8.done, bus8.product, dbg8);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus8.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL no_done_after_abort: got %0d pulses, want 0", dones);
    end
  endtask

  task automatic test_width4();
    logic [3:0] va [4] = '{4'b1001, 4'b1001, 4'b1000, 4'b1111};
    logic [3:0] vb [4] = '{4'b0011, 4'b0011, 4'b1000, 4'b1111};
    logic       vs [4] = '{1'b1,    1'b0,    1'b1,    1'b0};
    logic [7:0] ve [4] = '{8'hEB,   8'h1B,   8'h40,   8'hE1};
    logic [7:0] p; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op4(va[i], vb[i], vs[i], p, lat);
      n_cmp++;
      if (p !== ve[i] || lat !== 5) begin
        n_bad++;
        $display("FAIL w4_vector%0d: got %h lat %0d, want %h lat 5", i, p, lat, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b; logic sm; logic [15:0] p, e; int lat; logic bm, ba;
    int sa, sb;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      sm = (i % 2 == 1);
      sa = sm ? int'($signed(a)) : int'(a);
      sb = sm ? int'($signed(b)) : int'(b);
      e = 16'(sa * sb);
      run_op(a, b, sm, p, lat, bm, ba);
      n_cmp++;
      if (p !== e) begin
        n_bad++;
        $display("FAIL random%0d (%h*%h s=%b): got %h, want %h", i, a, b, sm, p, e);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_signed_basic();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_hold();
    test_reset_mid_op();
    test_width4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
